// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: FSM states, boot address, decode
// pipeline register layout and the line word-select helper.
package fetch_stage_pkg;

    localparam int unsigned FETCH_ADDR_W  = 32;
    localparam int unsigned FETCH_INSTR_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_BOOT_ADDR = 32'h0000_1000;

    typedef enum logic [1:0] {
        StRun,
        StWaitMiss,
        StHalt
    } fetch_state_t;

    typedef struct packed {
        logic                     valid;
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
        logic                     xcpt;
    } decode_pipe_t;

    // Bit position of the lowest bit of word `offset` within a cache line.
    function automatic int unsigned fetch_word_lsb(input int unsigned offset,
                                                   input int unsigned instr_width);
        return offset * instr_width;
    endfunction

endpackage

// File: rtl/fetch_word_select.sv
// Combinational extraction of one instruction word from an I$ line by word offset.
module fetch_word_select
    import fetch_stage_pkg::*;
#(
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned INSTR_WIDTH = 32,
    localparam int unsigned OFFS_W     = $clog2(LINE_WIDTH / INSTR_WIDTH)
) (
    input  logic [LINE_WIDTH-1:0]  line,
    input  logic [OFFS_W-1:0]      offset,
    output logic [INSTR_WIDTH-1:0] word
);

    always_comb begin
        word = line[fetch_word_lsb(32'(offset), INSTR_WIDTH) +: INSTR_WIDTH];
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues I$ lookups, extracts the instruction and fills the
// decode pipeline register; handles stalls, redirects and squashing of stale misses.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH          = 32,
    parameter int unsigned LINE_WIDTH          = 128,
    parameter int unsigned INSTR_WIDTH         = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = FETCH_BOOT_ADDR
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   icache_ready,
    output logic [ADDR_WIDTH-1:0]  icache_req_addr,
    output logic                   icache_req_valid,
    input  logic [LINE_WIDTH-1:0]  icache_rsp_data,
    input  logic                   icache_rsp_valid,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   decode_stall,
    output logic                   decode_valid,
    output logic [INSTR_WIDTH-1:0] decode_instr,
    output logic [ADDR_WIDTH-1:0]  decode_pc,
    output logic                   decode_xcpt_misaligned
);

    localparam int unsigned OFFS_W = $clog2(LINE_WIDTH / INSTR_WIDTH);

    fetch_state_t           state_ff, state_nxt;
    logic [ADDR_WIDTH-1:0]  pc_ff, pc_nxt;
    logic                   squash_ff, squash_nxt;
    logic                   hold_valid_ff, hold_valid_nxt;
    logic [INSTR_WIDTH-1:0] hold_instr_ff, hold_instr_nxt;
    decode_pipe_t           dec_ff, dec_nxt;

    logic [INSTR_WIDTH-1:0] rsp_word;
    logic                   ld;
    logic [INSTR_WIDTH-1:0] ld_instr;
    logic                   ld_xcpt;

    fetch_word_select #(
        .LINE_WIDTH  (LINE_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_word_select (
        .line   (icache_rsp_data),
        .offset (pc_ff[OFFS_W+1:2]),
        .word   (rsp_word)
    );

    always_comb begin
        state_nxt        = state_ff;
        pc_nxt           = pc_ff;
        squash_nxt       = squash_ff;
        hold_valid_nxt   = hold_valid_ff;
        hold_instr_nxt   = hold_instr_ff;
        dec_nxt          = dec_ff;
        icache_req_valid = 1'b0;
        ld               = 1'b0;
        ld_instr         = rsp_word;
        ld_xcpt          = 1'b0;

        if (!decode_stall) begin
            dec_nxt.valid = 1'b0;
        end

        if (redirect_valid) begin
            pc_nxt         = redirect_pc;
            dec_nxt.valid  = 1'b0;
            hold_valid_nxt = 1'b0;
            // An outstanding miss must still be drained; mark its response as stale.
            if (state_ff == StWaitMiss && !icache_rsp_valid) begin
                squash_nxt = 1'b1;
                state_nxt  = StWaitMiss;
            end else begin
                squash_nxt = 1'b0;
                state_nxt  = StRun;
            end
        end else begin
            unique case (state_ff)
                StRun: begin
                    if (hold_valid_ff) begin
                        if (!decode_stall) begin
                            ld             = 1'b1;
                            ld_instr       = hold_instr_ff;
                            hold_valid_nxt = 1'b0;
                        end
                    end else if (pc_ff[1:0] != 2'b00) begin
                        if (!decode_stall) begin
                            ld        = 1'b1;
                            ld_instr  = '0;
                            ld_xcpt   = 1'b1;
                            state_nxt = StHalt;
                        end
                    end else begin
                        icache_req_valid = reset & icache_ready & !decode_stall;
                        if (icache_req_valid) begin
                            if (icache_rsp_valid) begin
                                ld = 1'b1;
                            end else begin
                                state_nxt = StWaitMiss;
                            end
                        end
                    end
                end
                StWaitMiss: begin
                    if (icache_rsp_valid) begin
                        state_nxt = StRun;
                        if (squash_ff) begin
                            squash_nxt = 1'b0;
                        end else if (!decode_stall) begin
                            ld = 1'b1;
                        end else begin
                            hold_valid_nxt = 1'b1;
                            hold_instr_nxt = rsp_word;
                        end
                    end
                end
                StHalt: begin
                end
                default: begin
                    state_nxt = StRun;
                end
            endcase
        end

        if (ld) begin
            dec_nxt.valid = 1'b1;
            dec_nxt.instr = ld_instr;
            dec_nxt.pc    = pc_ff;
            dec_nxt.xcpt  = ld_xcpt;
            if (!ld_xcpt) begin
                pc_nxt = pc_ff + ADDR_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_ff      <= StRun;
            pc_ff         <= BOOT_ADDR;
            squash_ff     <= 1'b0;
            hold_valid_ff <= 1'b0;
            hold_instr_ff <= '0;
            dec_ff        <= '0;
        end else begin
            state_ff      <= state_nxt;
            pc_ff         <= pc_nxt;
            squash_ff     <= squash_nxt;
            hold_valid_ff <= hold_valid_nxt;
            hold_instr_ff <= hold_instr_nxt;
            dec_ff        <= dec_nxt;
        end
    end

    assign icache_req_addr        = pc_ff;
    assign decode_valid           = dec_ff.valid;
    assign decode_instr           = dec_ff.instr;
    assign decode_pc              = dec_ff.pc;
    assign decode_xcpt_misaligned = dec_ff.xcpt;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural I$ plus an in-order scoreboard of
// instructions expected at the decode register, and per-scenario inline checks.
module tb_fetch_stage;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int IW = 32;

    logic          clock;
    logic          reset;
    logic          icache_ready;
    logic [AW-1:0] icache_req_addr;
    logic          icache_req_valid;
    logic [LW-1:0] icache_rsp_data;
    logic          icache_rsp_valid;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          decode_stall;
    logic          decode_valid;
    logic [IW-1:0] decode_instr;
    logic [AW-1:0] decode_pc;
    logic          decode_xcpt_misaligned;

    logic          hit_mode;
    logic          fill_valid;
    logic [AW-1:0] fill_addr;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        xcpt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fetch_stage dut (
        .clock                  (clock),
        .reset                  (reset),
        .icache_ready           (icache_ready),
        .icache_req_addr        (icache_req_addr),
        .icache_req_valid       (icache_req_valid),
        .icache_rsp_data        (icache_rsp_data),
        .icache_rsp_valid       (icache_rsp_valid),
        .redirect_valid         (redirect_valid),
        .redirect_pc            (redirect_pc),
        .decode_stall           (decode_stall),
        .decode_valid           (decode_valid),
        .decode_instr           (decode_instr),
        .decode_pc              (decode_pc),
        .decode_xcpt_misaligned (decode_xcpt_misaligned)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_100C) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_word({a[31:4], 2'(i), 2'b00});
        return l;
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic xcpt);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.xcpt  = xcpt;
        return e;
    endfunction

    // Behavioural I$: instant hit in hit_mode, otherwise only explicit fills respond.
    assign icache_rsp_valid = (hit_mode & icache_req_valid) | fill_valid;
    assign icache_rsp_data  = fill_valid ? line_of(fill_addr) : line_of(icache_req_addr);

    // An entry is consumed by decode at the next edge when valid and not stalled.
    always @(negedge clock) begin
        exp_t e;
        if (reset && decode_valid && !decode_stall) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h xcpt=%b, required no entry",
                         decode_pc, decode_instr, decode_xcpt_misaligned);
            end else begin
                e = sb.pop_front();
                if ({decode_pc, decode_instr, decode_xcpt_misaligned} !== e) begin
                    errors++;
                    $display("FAIL sb_entry: got pc=%h instr=%h xcpt=%b, required pc=%h instr=%h xcpt=%b",
                             decode_pc, decode_instr, decode_xcpt_misaligned,
                             e.pc, e.instr, e.xcpt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        icache_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (icache_req_valid !== 1'b0) begin
            errors++; $display("FAIL rst_req_valid: got %b, required 0", icache_req_valid);
        end
        checks++;
        if (icache_req_addr !== 32'h0000_1000) begin
            errors++; $display("FAIL rst_pc: got %h, required 00001000", icache_req_addr);
        end
        checks++;
        if (decode_valid !== 1'b0) begin
            errors++; $display("FAIL rst_dec_valid: got %b, required 0", decode_valid);
        end
        checks++;
        if (decode_instr !== 32'h0 || decode_pc !== 32'h0 || decode_xcpt_misaligned !== 1'b0)
        begin
            errors++;
            $display("FAIL rst_dec_fields: got instr=%h pc=%h xcpt=%b, required all zero",
                     decode_instr, decode_pc, decode_xcpt_misaligned);
        end
    endtask

    task automatic test_hits();
        logic [31:0] a;
        hit_mode     = 1'b1;
        icache_ready = 1'b1;
        reset        = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(mk(32'h1000 + 32'(4 * i),
                                                    mem_word(32'h1000 + 32'(4 * i)), 1'b0));
        for (int i = 0; i < 4; i++) begin
            a = 32'h1000 + 32'(4 * i);
            #1;
            checks++;
            if (icache_req_valid !== 1'b1 || icache_req_addr !== a) begin
                errors++;
                $display("FAIL hit_req[%0d]: got valid=%b addr=%h, required valid=1 addr=%h",
                         i, icache_req_valid, icache_req_addr, a);
            end
            tick();
            checks++;
            if (decode_valid !== 1'b1 || decode_pc !== a) begin
                errors++;
                $display("FAIL hit_dec[%0d]: got valid=%b pc=%h, required valid=1 pc=%h",
                         i, decode_valid, decode_pc, a);
            end
        end
        icache_ready = 1'b0;
        hit_mode     = 1'b0;
        checks++;
        if (decode_instr !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL hit_word3: got %h, required deadbeef", decode_instr);
        end
        tick();
        checks++;
        if (decode_valid !== 1'b0) begin
            errors++; $display("FAIL hit_idle_valid: got %b, required 0", decode_valid);
        end
    endtask

    task automatic test_miss();
        reset        = 1'b0;
        icache_ready = 1'b0;
        tick();
        icache_ready = 1'b1;
        reset        = 1'b1;
        #1;
        checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h1000) begin
            errors++;
            $display("FAIL miss_req: got valid=%b addr=%h, required valid=1 addr=00001000",
                     icache_req_valid, icache_req_addr);
        end
        tick();
        for (int j = 1; j <= 10; j++) begin
            #1;
            checks++;
            if (icache_req_valid !== 1'b0 || decode_valid !== 1'b0) begin
                errors++;
                $display("FAIL miss_wait[%0d]: got req_valid=%b dec_valid=%b, required 0 0",
                         j, icache_req_valid, decode_valid);
            end
            if (j == 10) begin
                fill_valid = 1'b1;
                fill_addr  = 32'h1000;
                sb.push_back(mk(32'h1000, mem_word(32'h1000), 1'b0));
            end
            tick();
        end
        fill_valid   = 1'b0;
        icache_ready = 1'b0;
        checks++;
        if (decode_valid !== 1'b1 || decode_instr !== mem_word(32'h1000)) begin
            errors++;
            $display("FAIL miss_fill: got valid=%b instr=%h, required valid=1 instr=%h",
                     decode_valid, decode_instr, mem_word(32'h1000));
        end
        checks++;
        if (icache_req_addr !== 32'h1004) begin
            errors++; $display("FAIL miss_pc: got %h, required 00001004", icache_req_addr);
        end
        tick();
    endtask

    task automatic test_redirect_squash();
        icache_ready = 1'b1;
        #1;
        checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h1004) begin
            errors++;
            $display("FAIL sq_req: got valid=%b addr=%h, required valid=1 addr=00001004",
                     icache_req_valid, icache_req_addr);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        #1;
        checks++;
        if (icache_req_valid !== 1'b0) begin
            errors++; $display("FAIL sq_redir_req: got %b, required 0", icache_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (icache_req_addr !== 32'h2000 || decode_valid !== 1'b0) begin
            errors++;
            $display("FAIL sq_pc: got addr=%h dec_valid=%b, required addr=00002000 dec_valid=0",
                     icache_req_addr, decode_valid);
        end
        tick();
        tick();
        fill_valid = 1'b1;
        fill_addr  = 32'h1004;
        tick();
        fill_valid   = 1'b0;
        icache_ready = 1'b0;
        checks++;
        if (decode_valid !== 1'b0) begin
            errors++; $display("FAIL sq_drop: got dec_valid=%b, required 0", decode_valid);
        end
        tick();
        icache_ready = 1'b1;
        hit_mode     = 1'b1;
        #1;
        checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h2000) begin
            errors++;
            $display("FAIL sq_resume: got valid=%b addr=%h, required valid=1 addr=00002000",
                     icache_req_valid, icache_req_addr);
        end
        sb.push_back(mk(32'h2000, mem_word(32'h2000), 1'b0));
        tick();
        icache_ready = 1'b0;
        hit_mode     = 1'b0;
    endtask

    task automatic test_stall_fill();
        icache_ready = 1'b1;
        #1;
        tick();
        decode_stall = 1'b1;
        tick();
        fill_valid = 1'b1;
        fill_addr  = 32'h2004;
        sb.push_back(mk(32'h2004, mem_word(32'h2004), 1'b0));
        tick();
        fill_valid = 1'b0;
        checks++;
        if (decode_valid !== 1'b0) begin
            errors++; $display("FAIL st_held: got dec_valid=%b, required 0", decode_valid);
        end
        tick();
        decode_stall = 1'b0;
        #1;
        checks++;
        if (icache_req_valid !== 1'b0) begin
            errors++; $display("FAIL st_no_req: got %b, required 0", icache_req_valid);
        end
        tick();
        icache_ready = 1'b0;
        checks++;
        if (decode_valid !== 1'b1 || decode_pc !== 32'h2004 || icache_req_addr !== 32'h2008)
        begin
            errors++;
            $display("FAIL st_deliver: got valid=%b pc=%h next=%h, required 1 00002004 00002008",
                     decode_valid, decode_pc, icache_req_addr);
        end
        tick();
        checks++;
        if (decode_valid !== 1'b0) begin
            errors++; $display("FAIL st_dup: got dec_valid=%b, required 0", decode_valid);
        end
    endtask

    task automatic test_misaligned();
        icache_ready   = 1'b1;
        hit_mode       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (icache_req_valid !== 1'b0) begin
            errors++; $display("FAIL mis_req: got %b, required 0", icache_req_valid);
        end
        sb.push_back(mk(32'h2002, 32'h0, 1'b1));
        tick();
        checks++;
        if (decode_valid !== 1'b1 || decode_xcpt_misaligned !== 1'b1 ||
            decode_pc !== 32'h2002 || decode_instr !== 32'h0) begin
            errors++;
            $display("FAIL mis_dec: got v=%b x=%b pc=%h i=%h, required v=1 x=1 pc=00002002 i=0",
                     decode_valid, decode_xcpt_misaligned, decode_pc, decode_instr);
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (icache_req_valid !== 1'b0) begin
                errors++; $display("FAIL mis_halt[%0d]: got %b, required 0", k, icache_req_valid);
            end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h3000) begin
            errors++;
            $display("FAIL mis_resume: got valid=%b addr=%h, required valid=1 addr=00003000",
                     icache_req_valid, icache_req_addr);
        end
        sb.push_back(mk(32'h3000, mem_word(32'h3000), 1'b0));
        tick();
        icache_ready = 1'b0;
        hit_mode     = 1'b0;
        checks++;
        if (decode_pc !== 32'h3000 || decode_xcpt_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL mis_after: got pc=%h x=%b, required pc=00003000 x=0",
                     decode_pc, decode_xcpt_misaligned);
        end
    endtask

    task automatic test_reset_mid_miss();
        icache_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (icache_req_addr !== 32'h1000 || decode_valid !== 1'b0 || icache_req_valid !== 1'b0)
        begin
            errors++;
            $display("FAIL rm_async: got addr=%h dv=%b rv=%b, required addr=00001000 dv=0 rv=0",
                     icache_req_addr, decode_valid, icache_req_valid);
        end
        fill_valid = 1'b1;
        fill_addr  = 32'h3004;
        tick();
        fill_valid   = 1'b0;
        icache_ready = 1'b0;
        reset        = 1'b1;
        tick();
        fill_valid = 1'b1;
        fill_addr  = 32'h3004;
        tick();
        fill_valid = 1'b0;
        checks++;
        if (decode_valid !== 1'b0 || icache_req_addr !== 32'h1000) begin
            errors++;
            $display("FAIL rm_stray: got dv=%b addr=%h, required dv=0 addr=00001000",
                     decode_valid, icache_req_addr);
        end
        icache_ready = 1'b1;
        hit_mode     = 1'b1;
        sb.push_back(mk(32'h1000, mem_word(32'h1000), 1'b0));
        tick();
        icache_ready = 1'b0;
        hit_mode     = 1'b0;
        checks++;
        if (decode_valid !== 1'b1 || decode_pc !== 32'h1000) begin
            errors++;
            $display("FAIL rm_refetch: got dv=%b pc=%h, required dv=1 pc=00001000",
                     decode_valid, decode_pc);
        end
        tick();
    endtask

    initial begin
        reset          = 1'b0;
        icache_ready   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        decode_stall   = 1'b0;
        hit_mode       = 1'b0;
        fill_valid     = 1'b0;
        fill_addr      = '0;

        test_reset();
        test_hits();
        test_miss();
        test_redirect_squash();
        test_stall_fill();
        test_misaligned();
        test_reset_mid_miss();

        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by time limit, required finish");
        $fatal(1, "timeout");
    end

endmodule
